// File: rtl/adder_seq_chunked_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    // Slice index needs at least one bit even when there is a single slice.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_chunked_if.sv
// Operand/result handshake bundle for adder_seq_chunked.
interface adder_seq_chunked_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inp0;
    logic [WIDTH-1:0] inp1;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, inp0, inp1, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero
    );

    modport slave (
        input  in_valid, inp0, inp1, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero
    );

endinterface

// File: rtl/adder_seq_chunked_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder used for one slice per clock.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per clock (LS slice first),
// with carry, signed-overflow and zero flags and ready/valid on both sides.
module adder_seq_chunked
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    adder_seq_chunked_if.slave  bus
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("adder_seq_chunked: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef logic [NUM_CHUNKS-1:0][CHUNK-1:0] sliced_t;

    adder_state_t     state, state_next;
    logic [IDX_W-1:0] idx;
    sliced_t          a_q, b_q, sum_q, sum_next;
    logic             carry_q, carry_out_q, overflow_q, zero_q;
    logic             load, step, last;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    assign last = (idx == LAST_IDX);

    always_comb begin
        sum_next      = sum_q;
        sum_next[idx] = slice_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        load          = 1'b0;
        step          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is folded into the operands at capture: b is inverted and the +1 rides in on carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (load) begin
            a_q     <= bus.inp0;
            b_q     <= bus.sub ? ~bus.inp1 : bus.inp1;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx     <= '0;
            sum_q   <= '0;
        end else if (step) begin
            sum_q   <= sum_next;
            carry_q <= slice_c;
            if (last) begin
                carry_out_q <= slice_c;
                overflow_q  <= (a_q[NUM_CHUNKS-1][CHUNK-1] == b_q[NUM_CHUNKS-1][CHUNK-1]) &&
                               (slice_s[CHUNK-1] != a_q[NUM_CHUNKS-1][CHUNK-1]);
                zero_q      <= ~|sum_next;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign bus.sum      = sum_q;
    assign bus.carry    = carry_out_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Directed and reference-checked bench for adder_seq_chunked at three parameter sets.
`timescale 1ns/1ps
module tb_adder_seq_chunked;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    adder_seq_chunked_if #(.WIDTH(32)) m   ();
    adder_seq_chunked_if #(.WIDTH(16)) n16 ();
    adder_seq_chunked_if #(.WIDTH(32)) w32 ();

    adder_seq_chunked #(.WIDTH(32), .CHUNK(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(m));
    adder_seq_chunked #(.WIDTH(16), .CHUNK(4))  dut16 (.clk(clk), .rst_n(rst_n), .bus(n16));
    adder_seq_chunked #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(w32));

    // Drivers: present operands at IDLE, count edges to out_valid, then complete the handshake.
    task automatic op_m(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                        output logic [31:0] r_sum, output logic r_c, output logic r_o,
                        output logic r_z, output int lat);
        m.inp0 = a; m.inp1 = b; m.cin = c; m.sub = s; m.in_valid = 1'b1;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        lat = 0;
        while (!m.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        r_sum = m.sum; r_c = m.carry; r_o = m.overflow; r_z = m.zero;
        m.out_ready = 1'b1;
        @(posedge clk); #1;
        m.out_ready = 1'b0;
    endtask

    task automatic op_16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                         output logic [15:0] r_sum, output logic r_c, output logic r_o,
                         output logic r_z, output int lat);
        n16.inp0 = a; n16.inp1 = b; n16.cin = c; n16.sub = s; n16.in_valid = 1'b1;
        @(posedge clk); #1;
        n16.in_valid = 1'b0;
        lat = 0;
        while (!n16.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        r_sum = n16.sum; r_c = n16.carry; r_o = n16.overflow; r_z = n16.zero;
        n16.out_ready = 1'b1;
        @(posedge clk); #1;
        n16.out_ready = 1'b0;
    endtask

    task automatic op_32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                         output logic [31:0] r_sum, output logic r_c, output logic r_o,
                         output logic r_z, output int lat);
        w32.inp0 = a; w32.inp1 = b; w32.cin = c; w32.sub = s; w32.in_valid = 1'b1;
        @(posedge clk); #1;
        w32.in_valid = 1'b0;
        lat = 0;
        while (!w32.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        r_sum = w32.sum; r_c = w32.carry; r_o = w32.overflow; r_z = w32.zero;
        w32.out_ready = 1'b1;
        @(posedge clk); #1;
        w32.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (m.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b, expected 1", m.in_ready);
        end
        checks++;
        if (m.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b, expected 0", m.out_valid);
        end
        checks++;
        if ({m.sum, m.carry, m.overflow, m.zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got sum=%h c=%b o=%b z=%b, expected all zero",
                     m.sum, m.carry, m.overflow, m.zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_table(input string name, input logic s_mode,
                             input logic [31:0] ta[6], input logic [31:0] tb[6], input logic tc[6],
                             input logic [31:0] ts[6], input logic tco[6], input logic to[6],
                             input logic tz[6]);
        logic [31:0] r_sum;
        logic        r_c, r_o, r_z;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            op_m(ta[i], tb[i], tc[i], s_mode, r_sum, r_c, r_o, r_z, lat);
            checks++;
            if ({r_sum, r_c, r_o, r_z} !== {ts[i], tco[i], to[i], tz[i]}) begin
                errors++;
                $display("FAIL %s[%0d]: got sum=%h c=%b o=%b z=%b, expected sum=%h c=%b o=%b z=%b",
                         name, i, r_sum, r_c, r_o, r_z, ts[i], tco[i], to[i], tz[i]);
            end
            checks++;
            if (lat !== 4) begin
                errors++; $display("FAIL %s_latency[%0d]: got %0d, expected 4", name, i, lat);
            end
        end
    endtask

    task automatic test_add();
        logic [31:0] ta[6] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] tb[6] = '{32'd2, 32'd2,         32'hFFFF_FFFD, 32'd1,         32'd1, 32'd0};
        logic        tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ts[6] = '{32'd4, 32'd0,         32'hFFFF_FFFB, 32'h8000_0000, 32'd3, 32'd0};
        logic        tco[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        to[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        tz[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_table("add", 1'b0, ta, tb, tc, ts, tco, to, tz);
    endtask

    task automatic test_sub();
        logic [31:0] ta[6] = '{32'd3, 32'd5, 32'h8000_0000, 32'd5, 32'd7, 32'd0};
        logic [31:0] tb[6] = '{32'd5, 32'd3, 32'd1,         32'd3, 32'd7, 32'h8000_0000};
        logic        tc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ts[6] = '{32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'd2, 32'd0, 32'h8000_0000};
        logic        tco[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        to[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        tz[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        run_table("sub", 1'b1, ta, tb, tc, ts, tco, to, tz);
    endtask

    task automatic test_backpressure();
        logic [31:0] r_sum;
        logic        r_c, r_o, r_z;
        int          lat;
        m.inp0 = 32'd10; m.inp1 = 32'd20; m.cin = 1'b0; m.sub = 1'b0; m.in_valid = 1'b1;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        lat = 0;
        while (!m.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++;
        if (m.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_wait: out_valid=%b after %0d cycles, expected 1", m.out_valid, lat);
        end
        for (int i = 0; i < 5; i++) begin
            m.inp0     = 32'hDEAD_0000 + 32'(i);
            m.in_valid = i[0];
            @(posedge clk); #1;
            checks++;
            if ({m.out_valid, m.sum, m.carry, m.overflow, m.zero} !== {1'b1, 32'd30, 3'b000}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b sum=%h c=%b o=%b z=%b, expected v=1 sum=0000001e c=0 o=0 z=0",
                         i, m.out_valid, m.sum, m.carry, m.overflow, m.zero);
            end
            checks++;
            if (m.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready[%0d]: got %b, expected 0", i, m.in_ready);
            end
        end
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
        @(posedge clk); #1;
        m.out_ready = 1'b0;
        checks++;
        if (m.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release_valid: got %b, expected 0", m.out_valid);
        end
        checks++;
        if (m.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b, expected 1", m.in_ready);
        end
        op_m(32'd6, 32'd7, 1'b0, 1'b0, r_sum, r_c, r_o, r_z, lat);
        checks++;
        if ({r_sum, r_c, r_o, r_z, lat} !== {32'd13, 3'b000, 32'd4}) begin
            errors++;
            $display("FAIL bp_next_op: got sum=%h c=%b o=%b z=%b lat=%0d, expected sum=0000000d flags=0 lat=4",
                     r_sum, r_c, r_o, r_z, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r_sum;
        logic        r_c, r_o, r_z;
        int          lat;
        m.inp0 = 32'h0101_0101; m.inp1 = 32'h0101_0101; m.cin = 1'b0; m.sub = 1'b0; m.in_valid = 1'b1;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m.out_valid, m.in_ready} !== 2'b01) begin
            errors++; $display("FAIL midrst_ctrl: got v=%b rdy=%b, expected v=0 rdy=1", m.out_valid, m.in_ready);
        end
        checks++;
        if ({m.sum, m.carry, m.overflow, m.zero} !== 35'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got sum=%h c=%b o=%b z=%b, expected all zero",
                     m.sum, m.carry, m.overflow, m.zero);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        op_m(32'd4, 32'd8, 1'b0, 1'b0, r_sum, r_c, r_o, r_z, lat);
        checks++;
        if ({r_sum, r_c, r_o, r_z, lat} !== {32'd12, 3'b000, 32'd4}) begin
            errors++;
            $display("FAIL midrst_next_op: got sum=%h c=%b o=%b z=%b lat=%0d, expected sum=0000000c flags=0 lat=4",
                     r_sum, r_c, r_o, r_z, lat);
        end
    endtask

    task automatic test_sweep_w16();
        logic [15:0] a, b, r_sum, es;
        logic        c, s, r_c, r_o, r_z, ec, eo;
        logic [16:0] full;
        int          lat, sr;
        op_16(16'hFFFF, 16'h0001, 1'b0, 1'b0, r_sum, r_c, r_o, r_z, lat);
        checks++;
        if ({r_sum, r_c, r_o, r_z, lat} !== {16'h0000, 3'b101, 32'd4}) begin
            errors++;
            $display("FAIL w16_wrap: got sum=%h c=%b o=%b z=%b lat=%0d, expected sum=0000 c=1 o=0 z=1 lat=4",
                     r_sum, r_c, r_o, r_z, lat);
        end
        op_16(16'h7FFF, 16'h0001, 1'b0, 1'b0, r_sum, r_c, r_o, r_z, lat);
        checks++;
        if ({r_sum, r_c, r_o, r_z} !== {16'h8000, 3'b010}) begin
            errors++;
            $display("FAIL w16_ovf: got sum=%h c=%b o=%b z=%b, expected sum=8000 c=0 o=1 z=0",
                     r_sum, r_c, r_o, r_z);
        end
        for (int k = 0; k < 1000; k++) begin
            a = 16'($urandom); b = 16'($urandom);
            c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            if (k % 9 == 0) b = s ? a : 16'(-a);
            if (!s) begin
                full = {1'b0, a} + {1'b0, b} + {16'b0, c};
                es = full[15:0]; ec = full[16];
                sr = int'($signed(a)) + int'($signed(b)) + int'(c);
            end else begin
                es = a - b; ec = (a >= b);
                sr = int'($signed(a)) - int'($signed(b));
            end
            eo = (sr > 32767) || (sr < -32768);
            op_16(a, b, c, s, r_sum, r_c, r_o, r_z, lat);
            checks++;
            if ({r_sum, r_c, r_o, r_z, lat} !== {es, ec, eo, (es == 16'd0), 32'd4}) begin
                errors++;
                $display("FAIL w16_rand[%0d] a=%h b=%h cin=%b sub=%b: got sum=%h c=%b o=%b z=%b lat=%0d, expected sum=%h c=%b o=%b z=%b lat=4",
                         k, a, b, c, s, r_sum, r_c, r_o, r_z, lat, es, ec, eo, (es == 16'd0));
            end
        end
    endtask

    task automatic test_sweep_c32();
        logic [31:0] a, b, r_sum, es;
        logic        c, s, r_c, r_o, r_z, ec, eo;
        logic [32:0] full;
        int          lat;
        longint      sr;
        op_32(32'd2, 32'd2, 1'b0, 1'b0, r_sum, r_c, r_o, r_z, lat);
        checks++;
        if ({r_sum, r_c, r_o, r_z, lat} !== {32'd4, 3'b000, 32'd1}) begin
            errors++;
            $display("FAIL c32_basic: got sum=%h c=%b o=%b z=%b lat=%0d, expected sum=00000004 flags=0 lat=1",
                     r_sum, r_c, r_o, r_z, lat);
        end
        for (int k = 0; k < 1000; k++) begin
            a = $urandom; b = $urandom;
            c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            if (k % 9 == 0) b = s ? a : -a;
            if (k % 11 == 0) a = 32'h7FFF_FFFF;
            if (!s) begin
                full = {1'b0, a} + {1'b0, b} + {32'b0, c};
                es = full[31:0]; ec = full[32];
                sr = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
            end else begin
                es = a - b; ec = (a >= b);
                sr = longint'($signed(a)) - longint'($signed(b));
            end
            eo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            op_32(a, b, c, s, r_sum, r_c, r_o, r_z, lat);
            checks++;
            if ({r_sum, r_c, r_o, r_z, lat} !== {es, ec, eo, (es == 32'd0), 32'd1}) begin
                errors++;
                $display("FAIL c32_rand[%0d] a=%h b=%h cin=%b sub=%b: got sum=%h c=%b o=%b z=%b lat=%0d, expected sum=%h c=%b o=%b z=%b lat=1",
                         k, a, b, c, s, r_sum, r_c, r_o, r_z, lat, es, ec, eo, (es == 32'd0));
            end
        end
    endtask

    initial begin
        m.in_valid = 1'b0;   m.inp0 = '0;   m.inp1 = '0;   m.cin = 1'b0;   m.sub = 1'b0;   m.out_ready = 1'b0;
        n16.in_valid = 1'b0; n16.inp0 = '0; n16.inp1 = '0; n16.cin = 1'b0; n16.sub = 1'b0; n16.out_ready = 1'b0;
        w32.in_valid = 1'b0; w32.inp0 = '0; w32.inp1 = '0; w32.cin = 1'b0; w32.sub = 1'b0; w32.out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_sweep_w16();
        test_sweep_c32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adder_seq_chunked.md
Name: adder_seq_chunked

Overview:
- Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit add in CHUNK-bit slices, one slice per clock, least-significant slice first.
- Carry is held in a register between slices.
- Ready/valid handshakes on input and output.
- Provides signed-overflow and zero flags, so the datapath ALU can support MIPS add/addu/sub/subu at wide WIDTH without a long ripple path in one cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, slice width processed per cycle. WIDTH % CHUNK must be 0; otherwise elaboration fails with $error.
- NUM_CHUNKS is a derived localparam, WIDTH/CHUNK; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands/mode valid
- in_ready  output  1  block can accept operands
- inp0  input  WIDTH  operand A
- inp1  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1, cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- carry  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  sum == 0

Behaviour:
- Interface: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset (async assert, sync release):
  - state=IDLE.
  - sum=0, carry=0, overflow=0, zero=0, out_valid=0.
  - Slice index=0.
  - Operand registers cleared.
  - in_ready = (state==IDLE), so it reads 1 during reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a=inp0, b = sub ? ~inp1 : inp1, and carry_reg = sub ? 1 : cin.
  - Clear idx and the sum register; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle compute slice idx: {c, s} = a[idx] + b[idx] + carry_reg. Write s into sum[idx*CHUNK +: CHUNK] and set carry_reg=c.
  - When idx==NUM_CHUNKS-1: register carry, overflow and zero; go to DONE. Otherwise increment idx.
- DONE:
  - out_valid=1.
  - sum/carry/overflow/zero are stable and unchanged until the handshake.
  - On out_ready go to IDLE; out_valid drops on the next edge.
  - No back-to-back overlap: the next operand is accepted no earlier than the cycle after the output handshake.
- Latency:
  - Operands accepted at edge E0; out_valid is high after edge E0+NUM_CHUNKS.
  - With defaults this is 4 cycles; with CHUNK==WIDTH it is 1 cycle.
  - Throughput is at most one op per NUM_CHUNKS+2 cycles.
- Flags:
  - overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), using the inverted b in sub mode.
  - zero = ~|sum.
  - carry is the final-slice carry-out.
- Input changes: changes on inp0/inp1/cin/sub while not in IDLE are ignored, because operands are captured.
- Reset mid-operation (RUN or DONE): immediate return to IDLE, all outputs to their reset values, partial result discarded.
- out_ready while not in DONE is ignored.
- in_valid while not in IDLE is ignored; no capture.
- sum is not valid outside DONE and may hold partial slices during RUN. Checkers must sample only on out_valid.

Decomposition:
- adder_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} adder_state_t.
  - Helper function for slice-index width, $clog2(NUM_CHUNKS) with a minimum of 1.
- Sub-module chunk_adder:
  - Purely combinational, parametrised CHUNK-bit ripple adder.
  - Ports: a, b, cin, s, cout.
  - Instantiated once; the slice mux and registers live in adder_seq_chunked.

Test Plan:
- Default params, add: 2+2, cin=0 -> sum=4, carry=0, overflow=0, zero=0; out_valid exactly 4 cycles after the accept edge.
- Add: -2+2 -> sum=0, carry=1, zero=1. -2+(-3) -> sum=0xFFFFFFFB, carry=1, overflow=0. 0x7FFFFFFF+1 -> sum=0x80000000, overflow=1, carry=0.
- Sub: 3-5 -> sum=0xFFFFFFFE, carry=0. 5-3 -> sum=2, carry=1. 0x80000000-1 -> sum=0x7FFFFFFF, overflow=1. In sub mode, cin=1 is ignored.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable throughout.
  - Toggle inp0/in_valid meanwhile -> no capture, in_ready=0.
  - After the handshake, in_ready=1 the next cycle.
- Reset: assert rst_n=0 at idx=2 of RUN -> outputs zero immediately (before the next clk edge), state IDLE. Next op 4+8 -> sum=12 correct.
- Parameter sweep: WIDTH=16/CHUNK=4 gives 0xFFFF+1 -> sum=0, carry=1, latency 4. WIDTH=32/CHUNK=32 gives latency 1. Run 1000 random ops each, checked against A+B+cin and A-B reference-model results.
